// File: rtl/mano_control_sequencer_pkg.sv
// Shared encodings for the Mano basic-computer control sequencer: timing
// states, common-bus sources, ALU functions, opcodes and register-reference bits.
package mano_control_sequencer_pkg;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} state_t;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_DR   = 3'd2;
  localparam logic [2:0] ALU_CMA  = 3'd3;
  localparam logic [2:0] ALU_CIR  = 3'd4;
  localparam logic [2:0] ALU_CIL  = 3'd5;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  localparam int unsigned IR_I_BIT = 15;

  localparam logic [3:0] RR_CLA  = 4'd11;
  localparam logic [3:0] RR_CLE  = 4'd10;
  localparam logic [3:0] RR_CMA  = 4'd9;
  localparam logic [3:0] RR_CME  = 4'd8;
  localparam logic [3:0] RR_CIR  = 4'd7;
  localparam logic [3:0] RR_CIL  = 4'd6;
  localparam logic [3:0] RR_INC  = 4'd5;
  localparam logic [3:0] RR_SPA  = 4'd4;
  localparam logic [3:0] RR_SNA  = 4'd3;
  localparam logic [3:0] RR_SZA  = 4'd2;
  localparam logic [3:0] RR_SZE  = 4'd1;
  localparam logic [3:0] RR_HLT  = 4'd0;
  localparam logic [3:0] RR_NONE = 4'd15;

  // Highest set bit wins so that exactly one register-reference op is acted on.
  function automatic logic [3:0] regref_pick(input logic [11:0] rr);
    logic [3:0] pick;
    pick = RR_NONE;
    for (int unsigned k = 0; k < 12; k++)
      if (rr[k]) pick = k[3:0];
    return pick;
  endfunction

endpackage

// File: rtl/mano_control_sequencer_seq_counter_3.sv
// 3-bit sequence counter with synchronous clear (priority) and increment enable.
module seq_counter_3 (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] count
);

  always_ff @(posedge clk) begin
    if (clr)      count <= '0;
    else if (inc) count <= count + 3'd1;
  end

endmodule

// File: rtl/mano_control_sequencer.sv
// Mano basic-computer control unit: timing sequence, run flag and
// combinational decode of register/memory/bus/ALU strobes.
module mano_control_sequencer
  import mano_control_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] IR,
  input  logic        AC_ZERO,
  input  logic        AC_SIGN,
  input  logic        E_IN,
  input  logic        DR_ZERO,
  output logic [2:0]  BUS_SEL,
  output logic        AR_LD,
  output logic        AR_INR,
  output logic        PC_LD,
  output logic        PC_INR,
  output logic        DR_LD,
  output logic        DR_INR,
  output logic        AC_LD,
  output logic        AC_CLR,
  output logic        AC_INR,
  output logic        IR_LD,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic        E_CLR,
  output logic        E_CMP,
  output logic        E_LD,
  output logic [2:0]  ALU_OP,
  output logic        S_OUT,
  output logic [2:0]  SC_OUT
);

  logic [2:0] sc;
  logic       s;
  logic       ind;
  logic       sc_clr;
  logic       sc_inc;
  logic       halt;
  logic [2:0] op;
  logic [3:0] pick;
  state_t     t;

  assign t      = state_t'(sc);
  assign op     = IR[14:12];
  assign pick   = regref_pick(IR[11:0]);
  assign S_OUT  = s;
  assign SC_OUT = sc;

  seq_counter_3 u_sc (
    .clk   (clk_unused_guard(CLK)),
    .clr   (sc_clr),
    .inc   (sc_inc),
    .count (sc)
  );

  function automatic logic clk_unused_guard(input logic c);
    return c;
  endfunction

  // End-of-instruction detection; reset and the idle state also hold SC at 0.
  always_comb begin
    sc_clr = 1'b0;
    halt   = 1'b0;
    if (RST || !s) begin
      sc_clr = 1'b1;
    end else begin
      case (t)
        T0, T1, T2: sc_clr = 1'b0;
        T3: if (op == OP_REG) begin
              sc_clr = 1'b1;
              halt   = !ind && (pick == RR_HLT);
            end
        T4: sc_clr = (op == OP_STA) || (op == OP_BUN);
        T5: sc_clr = (op != OP_ISZ);
        default: sc_clr = 1'b1;
      endcase
    end
    sc_inc = !sc_clr;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s   <= 1'b0;
      ind <= 1'b0;
    end else begin
      if (!s)        s <= START;
      else if (halt) s <= 1'b0;
      if (s && t == T2) ind <= IR[IR_I_BIT];
    end
  end

  always_comb begin
    BUS_SEL = BUS_NONE;
    ALU_OP  = ALU_AND;
    AR_LD  = 1'b0; AR_INR = 1'b0; PC_LD  = 1'b0; PC_INR = 1'b0;
    DR_LD  = 1'b0; DR_INR = 1'b0; AC_LD  = 1'b0; AC_CLR = 1'b0;
    AC_INR = 1'b0; IR_LD  = 1'b0; MEM_RD = 1'b0; MEM_WR = 1'b0;
    E_CLR  = 1'b0; E_CMP  = 1'b0; E_LD   = 1'b0;
    if (s) begin
      case (t)
        T0: begin BUS_SEL = BUS_PC; AR_LD = 1'b1; end
        T1: begin BUS_SEL = BUS_MEM; MEM_RD = 1'b1; IR_LD = 1'b1; PC_INR = 1'b1; end
        T2: begin BUS_SEL = BUS_IR; AR_LD = 1'b1; end
        T3: begin
          if (op == OP_REG) begin
            if (!ind) begin
              case (pick)
                RR_CLA: AC_CLR = 1'b1;
                RR_CLE: E_CLR  = 1'b1;
                RR_CMA: begin AC_LD = 1'b1; ALU_OP = ALU_CMA; end
                RR_CME: E_CMP  = 1'b1;
                RR_CIR: begin AC_LD = 1'b1; E_LD = 1'b1; ALU_OP = ALU_CIR; end
                RR_CIL: begin AC_LD = 1'b1; E_LD = 1'b1; ALU_OP = ALU_CIL; end
                RR_INC: AC_INR = 1'b1;
                RR_SPA: PC_INR = !AC_SIGN;
                RR_SNA: PC_INR = AC_SIGN;
                RR_SZA: PC_INR = AC_ZERO;
                RR_SZE: PC_INR = !E_IN;
                default: ;
              endcase
            end
          end else if (ind) begin
            BUS_SEL = BUS_MEM; MEM_RD = 1'b1; AR_LD = 1'b1;
          end
        end
        T4: begin
          case (op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              BUS_SEL = BUS_MEM; MEM_RD = 1'b1; DR_LD = 1'b1;
            end
            OP_STA: begin BUS_SEL = BUS_AC; MEM_WR = 1'b1; end
            OP_BUN: begin BUS_SEL = BUS_AR; PC_LD = 1'b1; end
            OP_BSA: begin BUS_SEL = BUS_PC; MEM_WR = 1'b1; AR_INR = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (op)
            OP_AND: begin AC_LD = 1'b1; ALU_OP = ALU_AND; end
            OP_ADD: begin AC_LD = 1'b1; E_LD = 1'b1; ALU_OP = ALU_ADD; end
            OP_LDA: begin AC_LD = 1'b1; ALU_OP = ALU_DR; end
            OP_BSA: begin BUS_SEL = BUS_AR; PC_LD = 1'b1; end
            OP_ISZ: DR_INR = 1'b1;
            default: ;
          endcase
        end
        T6: if (op == OP_ISZ) begin
              BUS_SEL = BUS_DR; MEM_WR = 1'b1; PC_INR = DR_ZERO;
            end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mano_control_sequencer.sv
// Self-checking bench: instruction-level reference model compared every cycle,
// plus directed literal checks on known instruction sequences.
module tb_mano_control_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [15:0] IR = '0;
  logic        AC_ZERO = 1'b0, AC_SIGN = 1'b0, E_IN = 1'b0, DR_ZERO = 1'b0;
  logic [2:0]  BUS_SEL, ALU_OP, SC_OUT;
  logic        AR_LD, AR_INR, PC_LD, PC_INR, DR_LD, DR_INR, AC_LD, AC_CLR, AC_INR;
  logic        IR_LD, MEM_RD, MEM_WR, E_CLR, E_CMP, E_LD, S_OUT;

  mano_control_sequencer dut (
    .CLK(CLK), .RST(RST), .START(START), .IR(IR),
    .AC_ZERO(AC_ZERO), .AC_SIGN(AC_SIGN), .E_IN(E_IN), .DR_ZERO(DR_ZERO),
    .BUS_SEL(BUS_SEL), .AR_LD(AR_LD), .AR_INR(AR_INR), .PC_LD(PC_LD), .PC_INR(PC_INR),
    .DR_LD(DR_LD), .DR_INR(DR_INR), .AC_LD(AC_LD), .AC_CLR(AC_CLR), .AC_INR(AC_INR),
    .IR_LD(IR_LD), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .E_CLR(E_CLR), .E_CMP(E_CMP),
    .E_LD(E_LD), .ALU_OP(ALU_OP), .S_OUT(S_OUT), .SC_OUT(SC_OUT)
  );

  always #5 CLK = ~CLK;

  localparam logic [14:0] M_AR_LD  = 15'h4000, M_AR_INR = 15'h2000, M_PC_LD  = 15'h1000;
  localparam logic [14:0] M_PC_INR = 15'h0800, M_DR_LD  = 15'h0400, M_DR_INR = 15'h0200;
  localparam logic [14:0] M_AC_LD  = 15'h0100, M_AC_CLR = 15'h0080, M_AC_INR = 15'h0040;
  localparam logic [14:0] M_IR_LD  = 15'h0020, M_MEM_RD = 15'h0010, M_MEM_WR = 15'h0008;
  localparam logic [14:0] M_E_CLR  = 15'h0004, M_E_CMP  = 15'h0002, M_E_LD   = 15'h0001;

  logic [14:0] stb;
  logic [20:0] dut_vec;
  assign stb = {AR_LD, AR_INR, PC_LD, PC_INR, DR_LD, DR_INR, AC_LD, AC_CLR, AC_INR,
                IR_LD, MEM_RD, MEM_WR, E_CLR, E_CMP, E_LD};
  assign dut_vec = {BUS_SEL, ALU_OP, stb};

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction-level view (which step ends which instruction).
  logic m_run = 1'b0;
  int   m_t   = 0;
  logic m_i   = 1'b0;

  function automatic int last_step(input logic [2:0] op);
    if (op == 3'd7) return 3;
    if (op == 3'd3 || op == 3'd4) return 4;
    if (op == 3'd6) return 6;
    return 5;
  endfunction

  function automatic logic [20:0] exp_vec(input int t, input logic [15:0] ir, input logic i,
                                          input logic run, input logic az, input logic as,
                                          input logic e, input logic dz);
    logic [2:0]  bus = 3'd0, alu = 3'd0;
    logic [14:0] s = '0;
    logic [2:0]  op = ir[14:12];
    int h = -1;
    if (!run) return '0;
    case (t)
      0: begin bus = 3'd2; s = M_AR_LD; end
      1: begin bus = 3'd7; s = M_MEM_RD | M_IR_LD | M_PC_INR; end
      2: begin bus = 3'd5; s = M_AR_LD; end
      3: if (op == 3'd7 && !i) begin
           for (int k = 0; k < 12; k++) if (ir[k]) h = k;
           case (h)
             11: s = M_AC_CLR;
             10: s = M_E_CLR;
             9:  begin s = M_AC_LD; alu = 3'd3; end
             8:  s = M_E_CMP;
             7:  begin s = M_AC_LD | M_E_LD; alu = 3'd4; end
             6:  begin s = M_AC_LD | M_E_LD; alu = 3'd5; end
             5:  s = M_AC_INR;
             4:  s = as ? '0 : M_PC_INR;
             3:  s = as ? M_PC_INR : '0;
             2:  s = az ? M_PC_INR : '0;
             1:  s = e ? '0 : M_PC_INR;
             default: s = '0;
           endcase
         end else if (op != 3'd7 && i) begin
           bus = 3'd7; s = M_MEM_RD | M_AR_LD;
         end
      4: if (op <= 3'd2 || op == 3'd6) begin bus = 3'd7; s = M_MEM_RD | M_DR_LD; end
         else if (op == 3'd3) begin bus = 3'd4; s = M_MEM_WR; end
         else if (op == 3'd4) begin bus = 3'd1; s = M_PC_LD; end
         else if (op == 3'd5) begin bus = 3'd2; s = M_MEM_WR | M_AR_INR; end
      5: if (op <= 3'd2) begin
           alu = op; s = M_AC_LD | ((op == 3'd1) ? M_E_LD : 15'h0);
         end else if (op == 3'd5) begin bus = 3'd1; s = M_PC_LD; end
         else if (op == 3'd6) s = M_DR_INR;
      6: if (op == 3'd6) begin bus = 3'd3; s = M_MEM_WR | (dz ? M_PC_INR : 15'h0); end
      default: ;
    endcase
    return {bus, alu, s};
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_run <= 1'b0; m_t <= 0; m_i <= 1'b0;
    end else if (!m_run) begin
      m_run <= START; m_t <= 0;
    end else begin
      if (m_t == 2) m_i <= IR[15];
      m_t <= (m_t >= last_step(IR[14:12])) ? 0 : m_t + 1;
      if (m_t == 3 && IR[14:12] == 3'd7 && !m_i && IR[11:0] == 12'h001) m_run <= 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_vec", dut_vec, exp_vec(m_t, IR, m_i, m_run, AC_ZERO, AC_SIGN, E_IN, DR_ZERO));
      chk("model_sc", SC_OUT, m_t);
      chk("model_s", S_OUT, m_run);
      chk("rd_wr_excl", MEM_RD & MEM_WR, 0);
      chk("sc_not7", SC_OUT == 3'd7, 0);
    end
  end

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic adv(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    adv(2);
    chk_en = 1'b1;
    RST = 1'b0;
    chk("rst_s", S_OUT, 0);
    chk("rst_sc", SC_OUT, 0);
    chk("rst_vec", dut_vec, 0);

    // LDA direct
    IR = 16'h2123; START = 1'b1; cyc(); START = 1'b0;
    chk("lda_t0", dut_vec, {3'd2, 3'd0, M_AR_LD});
    cyc(); chk("lda_t1", dut_vec, {3'd7, 3'd0, M_MEM_RD | M_IR_LD | M_PC_INR});
    cyc(); chk("lda_t2", dut_vec, {3'd5, 3'd0, M_AR_LD});
    cyc(); chk("lda_t3", dut_vec, 0);
    cyc(); chk("lda_t4", dut_vec, {3'd7, 3'd0, M_MEM_RD | M_DR_LD});
    cyc(); chk("lda_t5", dut_vec, {3'd0, 3'd2, M_AC_LD});
    cyc(); chk("lda_end_sc", SC_OUT, 0); chk("lda_end_s", S_OUT, 1);

    // ADD indirect
    IR = 16'h9050; adv(3);
    chk("add_t3", dut_vec, {3'd7, 3'd0, M_MEM_RD | M_AR_LD});
    adv(2);
    chk("add_t5", dut_vec, {3'd0, 3'd1, M_AC_LD | M_E_LD});
    cyc();

    // ISZ with and without DR_ZERO
    IR = 16'h6010; DR_ZERO = 1'b1; adv(6);
    chk("isz_t6_z", dut_vec, {3'd3, 3'd0, M_MEM_WR | M_PC_INR});
    cyc(); DR_ZERO = 1'b0; adv(6);
    chk("isz_t6_nz", dut_vec, {3'd3, 3'd0, M_MEM_WR});
    cyc();

    // SPA with AC positive, then HLT
    IR = 16'h7010; AC_SIGN = 1'b0; adv(3);
    chk("spa_t3", dut_vec, {3'd0, 3'd0, M_PC_INR});
    cyc();
    IR = 16'h7001; adv(3);
    chk("hlt_t3_s", S_OUT, 1);
    cyc();
    chk("hlt_s", S_OUT, 0); chk("hlt_sc", SC_OUT, 0);
    adv(3);
    chk("hlt_idle", dut_vec, 0);
    START = 1'b1; cyc(); START = 1'b0;
    chk("resume_t0", dut_vec, {3'd2, 3'd0, M_AR_LD});

    // Reset in T4 of BSA
    IR = 16'h5100; adv(4);
    chk("bsa_t4", dut_vec, {3'd2, 3'd0, M_MEM_WR | M_AR_INR});
    RST = 1'b1; cyc(); RST = 1'b0;
    chk("bsa_rst_sc", SC_OUT, 0); chk("bsa_rst_s", S_OUT, 0);
    chk("bsa_rst_wr", MEM_WR, 0); chk("bsa_rst_pc", PC_LD, 0);

    // Random instructions; IR changes only at instruction boundaries
    for (int n = 0; n < 10000; n++) begin
      START   = ($urandom_range(7) == 0);
      RST     = ($urandom_range(599) == 0);
      AC_ZERO = $urandom_range(1);
      AC_SIGN = $urandom_range(1);
      E_IN    = $urandom_range(1);
      DR_ZERO = $urandom_range(1);
      if (!m_run || m_t == 0) IR = 16'($urandom);
      cyc();
    end
    RST = 1'b0; START = 1'b0;
    @(negedge CLK); #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
